// File: rtl/reg_file_pkg.sv
// Shared constants and helpers for the 2-read/1-write register file.
package reg_file_pkg;

   localparam int READ_COMB = 0;
   localparam int READ_REG  = 1;

   localparam int                            DEFAULT_DATA_WIDTH = 8;
   localparam logic [DEFAULT_DATA_WIDTH-1:0] ZERO_DATA          = '0;

   // Minimum index width for a given register count; never below 1 bit.
   function automatic int clog2(input int value);
      int width;
      width = 1;
      for (int i = 1; i < 31; i++) begin
         if ((1 << i) < value) width = i + 1;
      end
      return width;
   endfunction

endpackage

// File: rtl/reg_file_if.sv
// Decode/ALU-side bundle of the register file: one write port, two read ports.
interface reg_file_if import reg_file_pkg::*; #(
   parameter  int DATA_WIDTH = 8,
   parameter  int DEPTH      = 8,
   localparam int ADDR_WIDTH = clog2(DEPTH)
) ();

   logic                  write_en;
   logic [ADDR_WIDTH-1:0] write_addr;
   logic [DATA_WIDTH-1:0] write_data;
   logic [ADDR_WIDTH-1:0] read_addr1;
   logic [ADDR_WIDTH-1:0] read_addr2;
   logic [DATA_WIDTH-1:0] out1;
   logic [DATA_WIDTH-1:0] out2;

   modport master (
      output write_en, write_addr, write_data, read_addr1, read_addr2,
      input  out1, out2
   );

   modport slave (
      input  write_en, write_addr, write_data, read_addr1, read_addr2,
      output out1, out2
   );

endinterface

// File: rtl/reg_file_read_port.sv
// One read port: range check, DEPTH:1 mux, zero-register mask and optional
// falling-edge output register with write-first bypass.
module reg_file_read_port import reg_file_pkg::*; #(
   parameter  int DATA_WIDTH = 8,
   parameter  int DEPTH      = 8,
   parameter  int READ_MODE  = READ_COMB,
   parameter  int ZERO_REG   = 0,
   localparam int ADDR_WIDTH = clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [DATA_WIDTH-1:0] regs_i [DEPTH],
   input  logic [ADDR_WIDTH-1:0] read_addr_i,
   input  logic                  write_legal_i,
   input  logic [ADDR_WIDTH-1:0] write_addr_i,
   input  logic [DATA_WIDTH-1:0] write_data_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);

   logic                  in_range;
   logic                  zero_hit;
   logic                  bypass;
   logic [DATA_WIDTH-1:0] mux_data;
   logic [DATA_WIDTH-1:0] read_data;

   always_comb begin
      in_range = 32'(read_addr_i) < DEPTH;
      zero_hit = (ZERO_REG != 0) && (read_addr_i == '0);
      mux_data = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (32'(read_addr_i) == i) mux_data = regs_i[i];
      end
      read_data = (in_range && !zero_hit) ? mux_data : '0;
      // Only a write that will actually land may be forwarded.
      bypass    = write_legal_i && (write_addr_i == read_addr_i);
   end

   generate
      if (READ_MODE == READ_REG) begin : g_registered
         logic [DATA_WIDTH-1:0] rdata_q;
         logic [DATA_WIDTH-1:0] rdata_d;

         always_comb rdata_d = bypass ? write_data_i : read_data;

         always_ff @(negedge clk) begin
            if (!reset_n) rdata_q <= '0;
            else          rdata_q <= rdata_d;
         end

         assign rdata_o = rdata_q;
      end else begin : g_combinational
         logic unused_comb_inputs;
         assign unused_comb_inputs = ^{clk, reset_n, bypass, write_data_i};
         assign rdata_o = read_data;
      end
   endgenerate

endmodule

// File: rtl/reg_file_2r1w.sv
// Parametrised 2R1W register file between instruction decode and the ALU;
// storage, write decode and clear live here, read ports are sub-modules.
module reg_file_2r1w import reg_file_pkg::*; #(
   parameter  int DATA_WIDTH = 8,
   parameter  int DEPTH      = 8,
   parameter  int READ_MODE  = READ_COMB,
   parameter  int ZERO_REG   = 0,
   localparam int ADDR_WIDTH = clog2(DEPTH)
) (
   input logic       clk,
   input logic       reset_n,
   reg_file_if.slave bus
);

   logic [DATA_WIDTH-1:0] regs_q [DEPTH];
   logic [DATA_WIDTH-1:0] regs_d [DEPTH];
   logic                  write_legal;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      write_legal = bus.write_en
                 && (32'(bus.write_addr) < DEPTH)
                 && !((ZERO_REG != 0) && (bus.write_addr == '0));
      regs_d = regs_q;
      for (int i = 0; i < DEPTH; i++) begin
         if (write_legal && (32'(bus.write_addr) == i)) regs_d[i] = bus.write_data;
      end
   end

   // NOTE: the array is deliberately cleared on reset; this forces flops rather than a RAM macro.
   // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
   always_ff @(negedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      end else begin
         regs_q <= regs_d;
      end
   end

   reg_file_read_port #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .READ_MODE  (READ_MODE),
      .ZERO_REG   (ZERO_REG)
   ) u_read_port1 (
      .clk           (clk),
      .reset_n       (reset_n),
      .regs_i        (regs_q),
      .read_addr_i   (bus.read_addr1),
      .write_legal_i (write_legal),
      .write_addr_i  (bus.write_addr),
      .write_data_i  (bus.write_data),
      .rdata_o       (bus.out1)
   );

   reg_file_read_port #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .READ_MODE  (READ_MODE),
      .ZERO_REG   (ZERO_REG)
   ) u_read_port2 (
      .clk           (clk),
      .reset_n       (reset_n),
      .regs_i        (regs_q),
      .read_addr_i   (bus.read_addr2),
      .write_legal_i (write_legal),
      .write_addr_i  (bus.write_addr),
      .write_data_i  (bus.write_data),
      .rdata_o       (bus.out2)
   );

endmodule
